// File: rtl/demux_1to8_module.sv
// 1-to-N demultiplexer: steers Din onto lane S and drives IDLE_VAL on every other lane.
// The output stage is either registered on clk with async active-low reset, or purely combinational.
module demux_1to8_module #(
   parameter int unsigned           SEL_W    = 3,
   parameter int unsigned           DATA_W   = 1,
   parameter bit                    OUT_REG  = 1'b1,
   parameter logic [DATA_W-1:0]     IDLE_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             Din,
   input  logic [SEL_W-1:0]              S,
   output logic [DATA_W*(2**SEL_W)-1:0]  Y
);

   localparam int unsigned N = 2 ** SEL_W;

   logic [DATA_W*N-1:0] next_y;
   logic [DATA_W*N-1:0] idle_bus;

   always_comb begin
      idle_bus = '0;
      for (int k = 0; k < N; k++) begin
         idle_bus[k*DATA_W +: DATA_W] = IDLE_VAL;
      end
   end

   // An X/Z select makes the equality unknown, which falls to the idle branch.
   always_comb begin
      next_y = idle_bus;
      for (int k = 0; k < N; k++) begin
         if (S == SEL_W'(k)) begin
            next_y[k*DATA_W +: DATA_W] = Din;
         end
      end
   end

   if (OUT_REG) begin : g_reg
      logic [DATA_W*N-1:0] y_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            y_q <= idle_bus;
         end else begin
            y_q <= next_y;
         end
      end

      assign Y = y_q;
   end else begin : g_comb
      assign Y = next_y;
   end

endmodule

// File: tb/tb_demux_1to8_module.sv
// Directed self-checking bench for demux_1to8_module: a registered default
// instance plus a combinational (OUT_REG = 0) instance driven from the same inputs.
module tb_demux_1to8_module;

   logic       clk;
   logic       rst_n;
   logic       din;
   logic [2:0] s;
   logic [7:0] y;
   logic [7:0] yc;

   int errors = 0;
   int checks = 0;

   demux_1to8_module dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Din   (din),
      .S     (s),
      .Y     (y)
   );

   demux_1to8_module #(
      .OUT_REG (1'b0)
   ) dut_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .Din   (din),
      .S     (s),
      .Y     (yc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      din   = 1'b1;
      s     = 3'b010;

      // Async reset: asserted before any rising edge.
      #1 rst_n = 1'b0;
      #1 check("reset_async", y, 8'h00);
      check("comb_ignores_reset", yc, 8'h04);
      @(posedge clk); #1;
      check("reset_hold", y, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      #1 check("reset_release_no_edge", y, 8'h00);
      @(posedge clk); #1;
      check("reset_first_edge", y, 8'h04);

      // Din = 1 sweep; Y follows S one cycle later.
      @(negedge clk) s = 3'd0;
      #1 check("latency_old_value", y, 8'h04);
      @(posedge clk); #1;
      check("sweep1_s0", y, 8'h01);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk) s = 3'(i);
         @(posedge clk); #1;
         check($sformatf("sweep1_s%0d", i), y, 8'(1 << i));
      end

      // Din = 0 sweep: every lane idle.
      din = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) s = 3'(i);
         @(posedge clk); #1;
         check($sformatf("sweep0_s%0d", i), y, 8'h00);
      end

      // Toggle Din on lane 5.
      @(negedge clk) begin s = 3'b101; din = 1'b1; end
      @(posedge clk); #1;
      check("toggle_hi_a", y, 8'h20);
      @(negedge clk) din = 1'b0;
      @(posedge clk); #1;
      check("toggle_lo", y, 8'h00);
      @(negedge clk) din = 1'b1;
      @(posedge clk); #1;
      check("toggle_hi_b", y, 8'h20);

      // Reset mid-sweep while lane 4 is active, asserted while clk is high.
      @(negedge clk) s = 3'd4;
      @(posedge clk); #1;
      check("mid_before_reset", y, 8'h10);
      #1 rst_n = 1'b0;
      #1 check("mid_reset_immediate", y, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      #1 check("mid_release_no_edge", y, 8'h00);
      @(posedge clk); #1;
      check("mid_resume_s4", y, 8'h10);
      @(negedge clk) s = 3'd5;
      @(posedge clk); #1;
      check("mid_resume_s5", y, 8'h20);

      // Combinational build: no clock edge between stimulus and check.
      @(negedge clk) begin din = 1'b1; s = 3'b111; end
      #1 check("comb_s7", yc, 8'h80);
      check("reg_not_yet_s7", y, 8'h20);
      din = 1'b0;
      #1 check("comb_din0", yc, 8'h00);
      din = 1'b1; s = 3'b000;
      #1 check("comb_s0", yc, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
